// File: rtl/video_pkg.sv
// Shared video definitions for the frame-capture slice: capture FSM states,
// default window geometry and BRAM address width, and the measurement
// counter width with its saturating increment helper.
package video_pkg;

  localparam int unsigned H_DEFAULT      = 500;
  localparam int unsigned V_DEFAULT      = 500;
  localparam int unsigned ADDR_W_DEFAULT = 18;
  localparam int unsigned CNT_W          = 12;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capState_e;

  // Counters stick at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_capture_meas.sv
// Input-side timing measurement for vga_capture: de/vsync edge detection,
// the column and line counters, and the widest-line tracker. Both counters
// saturate at 4095. colIdx/lineIdx give the position of the pixel presented
// this cycle; lineNext/maxColNext are the values the registers take at the
// coming edge, so the top can latch a frame's measurements on the
// terminating vsync edge without losing the last cycle.
module vga_capture_meas
  import video_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             lineClear,
  output logic             vsyncRise,
  output logic [CNT_W-1:0] colIdx,
  output logic [CNT_W-1:0] lineIdx,
  output logic [CNT_W-1:0] lineNext,
  output logic [CNT_W-1:0] maxColNext
);

  logic             de_q;
  logic             vsync_q;
  logic [CNT_W-1:0] colCnt_q;
  logic [CNT_W-1:0] colCnt_d;
  logic [CNT_W-1:0] line_q;
  logic [CNT_W-1:0] line_d;
  logic [CNT_W-1:0] maxCol_q;
  logic [CNT_W-1:0] maxCol_d;
  logic             deRise;
  logic             deFall;

  // Edge detection and next-state of the column, line and max-column counters.
  always_comb begin
    deRise    = de & ~de_q;
    deFall    = ~de & de_q;
    vsyncRise = vsync & ~vsync_q;

    colIdx   = deRise ? '0 : colCnt_q;
    colCnt_d = colCnt_q;
    if (de) begin
      colCnt_d = satInc(colIdx);
    end else if (hsync) begin
      colCnt_d = '0;
    end

    line_d = line_q;
    if (lineClear) begin
      line_d = '0;
    end else if (deFall) begin
      line_d = satInc(line_q);
    end

    maxCol_d = maxCol_q;
    if (lineClear) begin
      maxCol_d = '0;
    end else if (de && (colCnt_d > maxCol_q)) begin
      maxCol_d = colCnt_d;
    end
  end

  // Edge-detect history and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q     <= 1'b0;
      vsync_q  <= 1'b0;
      colCnt_q <= '0;
      line_q   <= '0;
      maxCol_q <= '0;
    end else begin
      de_q     <= de;
      vsync_q  <= vsync;
      colCnt_q <= colCnt_d;
      line_q   <= line_d;
      maxCol_q <= maxCol_d;
    end
  end

  assign lineIdx    = line_q;
  assign lineNext   = line_d;
  assign maxColNext = maxCol_d;

endmodule

// File: rtl/vga_capture.sv
// Single-frame VGA capture into a BRAM write port. A start request arms the
// block, the next vsync rising edge begins capture and the following one
// ends it with a one-cycle done pulse. Pixels inside the H x V window are
// written at line*H+col one cycle after they arrive.
// Build option: define VGA_CAPTURE_GRAY_EN to store (r + 2g + b) >> 2
// instead of the red channel.
module vga_capture
  import video_pkg::*;
#(
  parameter int unsigned H      = H_DEFAULT,
  parameter int unsigned V      = V_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              de,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              start,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic              wea,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  h_meas,
  output logic [CNT_W-1:0]  v_meas
);

  capState_e         state_q;
  capState_e         state_d;
  logic              vsyncRise;
  logic              lineClear;
  logic [CNT_W-1:0]  colIdx;
  logic [CNT_W-1:0]  lineIdx;
  logic [CNT_W-1:0]  lineNext;
  logic [CNT_W-1:0]  maxColNext;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0]        pixData;
  logic              wea_q;
  logic [ADDR_W-1:0] addra_q;
  logic [ADDR_W-1:0] addra_d;
  logic [7:0]        dina_q;
  logic [7:0]        dina_d;
  logic [CNT_W-1:0]  hMeas_q;
  logic [CNT_W-1:0]  hMeas_d;
  logic [CNT_W-1:0]  vMeas_q;
  logic [CNT_W-1:0]  vMeas_d;
  logic              frameEnd;

  assign lineClear = (state_q == ARM) && vsyncRise;
  assign frameEnd  = (state_q == CAPTURE) && vsyncRise;

  vga_capture_meas u_meas (
    .clk       (clk),
    .rst       (rst),
    .de        (de),
    .hsync     (hsync),
    .vsync     (vsync),
    .lineClear (lineClear),
    .vsyncRise (vsyncRise),
    .colIdx    (colIdx),
    .lineIdx   (lineIdx),
    .lineNext  (lineNext),
    .maxColNext(maxColNext)
  );

`ifdef VGA_CAPTURE_GRAY_EN
  logic [9:0] graySum;
  assign graySum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
  assign pixData = graySum[9:2];
`else
  logic unusedColour;
  assign unusedColour = ^{g, b};
  assign pixData      = r;
`endif

  // Capture sequencing: start is only honoured from IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        busy = 1'b1;
        if (vsyncRise) state_d = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (vsyncRise) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window test, linear address and next values of the write port and measurements.
  always_comb begin
    wrEn    = (state_q == CAPTURE) && de && (32'(colIdx) < H) && (32'(lineIdx) < V);
    wrAddr  = ADDR_W'(lineIdx) * ADDR_W'(H) + ADDR_W'(colIdx);
    addra_d = wrEn ? wrAddr : addra_q;
    dina_d  = wrEn ? pixData : dina_q;
    hMeas_d = frameEnd ? maxColNext : hMeas_q;
    vMeas_d = frameEnd ? lineNext : vMeas_q;
  end

  // State, registered BRAM port and held measurements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      hMeas_q <= '0;
      vMeas_q <= '0;
    end else begin
      state_q <= state_d;
      wea_q   <= wrEn;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      hMeas_q <= hMeas_d;
      vMeas_q <= vMeas_d;
    end
  end

  assign wea    = wea_q;
  assign addra  = addra_q;
  assign dina   = dina_q;
  assign h_meas = hMeas_q;
  assign v_meas = vMeas_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with a small 8x6 window so whole frames
// stay short. A negedge monitor records every BRAM write into a memory
// model; frames are driven from tasks and expectations are computed here.
module tb_vga_capture;
  import video_pkg::*;

  localparam int unsigned TH     = 8;
  localparam int unsigned TV     = 6;
  localparam int unsigned TADDRW = 8;

  logic              clk;
  logic              rst;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              de;
  logic              hsync;
  logic              vsync;
  logic              start;
  logic [TADDRW-1:0] addra;
  logic [7:0]        dina;
  logic              wea;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  h_meas;
  logic [CNT_W-1:0]  v_meas;

  int checkCount;
  int failCount;
  int writeCount;
  int doneCount;
  int lastAddr;
  int snapWrites;
  logic [7:0] mem [0:(1<<TADDRW)-1];
  logic       written [0:(1<<TADDRW)-1];

  vga_capture #(.H(TH), .V(TV), .ADDR_W(TADDRW)) dut (
    .clk   (clk),
    .rst   (rst),
    .r     (r),
    .g     (g),
    .b     (b),
    .de    (de),
    .hsync (hsync),
    .vsync (vsync),
    .start (start),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .busy  (busy),
    .done  (done),
    .h_meas(h_meas),
    .v_meas(v_meas)
  );

  // Free-running pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write and done pulse, sampled away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wea) begin
        writeCount++;
        lastAddr = int'(addra);
        mem[addra] = dina;
        written[addra] = 1'b1;
      end
      if (done) doneCount++;
    end
  end

  function automatic logic [7:0] pixR(input int l, input int c);
    return 8'(l * 16 + c + 1);
  endfunction
  function automatic logic [7:0] pixG(input int l, input int c);
    return 8'(c * 7 + 3 + l);
  endfunction
  function automatic logic [7:0] pixB(input int l, input int c);
    return 8'(255 - l * 5 - c);
  endfunction
  function automatic logic [7:0] expPix(input int l, input int c);
    logic [9:0] s;
    s = {2'b00, pixR(l, c)} + {1'b0, pixG(l, c), 1'b0} + {2'b00, pixB(l, c)};
`ifdef VGA_CAPTURE_GRAY_EN
    return s[9:2];
`else
    return pixR(l, c);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic applyStimulus(input logic deV, input logic hsV, input logic vsV, input logic stV,
                               input logic [7:0] rV, input logic [7:0] gV, input logic [7:0] bV);
    de = deV; hsync = hsV; vsync = vsV; start = stV; r = rV; g = gV; b = bV;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic pulseStart();
    applyStimulus(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic vsyncPulse();
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    idle(1);
  endtask

  task automatic sendLine(input int l, input int w, input logic deOn);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    idle(1);
    for (int c = 0; c < w; c++) applyStimulus(deOn, 0, 0, 0, pixR(l, c), pixG(l, c), pixB(l, c));
    idle(2);
  endtask

  task automatic sendFrame(input int w, input int hgt, input logic deOn);
    vsyncPulse();
    idle(2);
    for (int l = 0; l < hgt; l++) sendLine(l, w, deOn);
    idle(2);
  endtask

  task automatic clearModel();
    writeCount = 0;
    doneCount  = 0;
    lastAddr   = -1;
    for (int i = 0; i < (1 << TADDRW); i++) begin
      mem[i] = 8'h00;
      written[i] = 1'b0;
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    clearModel();
    rst = 1'b1;
    de = 0; hsync = 0; vsync = 0; start = 0; r = 0; g = 0; b = 0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_wea",   32'(wea),    0);
    checkOutput("rst_busy",  32'(busy),   0);
    checkOutput("rst_done",  32'(done),   0);
    checkOutput("rst_addra", 32'(addra),  0);
    checkOutput("rst_dina",  32'(dina),   0);
    checkOutput("rst_hmeas", 32'(h_meas), 0);
    checkOutput("rst_vmeas", 32'(v_meas), 0);
    rst = 1'b0;
    idle(3);

    $display("[TB] oversized 10x7 frame into 8x6 window");
    clearModel();
    pulseStart();
    checkOutput("arm_busy", 32'(busy), 1);
    sendFrame(10, 7, 1);
    checkOutput("cap_busy", 32'(busy), 1);
    vsyncPulse();
    idle(4);
    checkOutput("big_writes", 32'(writeCount), 48);
    checkOutput("big_last",   32'(lastAddr),   47);
    checkOutput("big_done",   32'(doneCount),  1);
    checkOutput("big_hmeas",  32'(h_meas),     10);
    checkOutput("big_vmeas",  32'(v_meas),     7);
    checkOutput("big_busy",   32'(busy),       0);
    for (int l = 0; l < int'(TV); l++)
      for (int c = 0; c < int'(TH); c++)
        checkOutput($sformatf("big_mem_l%0d_c%0d", l, c), 32'(mem[l * int'(TH) + c]), 32'(expPix(l, c)));

    $display("[TB] undersized 5x3 frame");
    clearModel();
    pulseStart();
    sendFrame(5, 3, 1);
    vsyncPulse();
    idle(4);
    checkOutput("small_writes",   32'(writeCount), 15);
    checkOutput("small_last",     32'(lastAddr),   20);
    checkOutput("small_l1c0_wr",  32'(written[8]), 1);
    checkOutput("small_l1c0_dat", 32'(mem[8]),     32'(expPix(1, 0)));
    checkOutput("small_l0c5_wr",  32'(written[5]), 0);
    checkOutput("small_done",     32'(doneCount),  1);
    checkOutput("small_hmeas",    32'(h_meas),     5);
    checkOutput("small_vmeas",    32'(v_meas),     3);

    $display("[TB] frame without de");
    clearModel();
    pulseStart();
    sendFrame(6, 4, 0);
    vsyncPulse();
    idle(4);
    checkOutput("node_writes", 32'(writeCount), 0);
    checkOutput("node_done",   32'(doneCount),  1);
    checkOutput("node_hmeas",  32'(h_meas),     0);
    checkOutput("node_vmeas",  32'(v_meas),     0);

    $display("[TB] colour pixel on the terminating vsync edge");
    clearModel();
    pulseStart();
    vsyncPulse();
    idle(2);
    applyStimulus(1, 0, 1, 0, 8'h10, 8'h80, 8'hF0);
    checkOutput("col_wea",   32'(wea),   1);
    checkOutput("col_addra", 32'(addra), 0);
`ifdef VGA_CAPTURE_GRAY_EN
    checkOutput("col_dina",  32'(dina),  32'h80);
`else
    checkOutput("col_dina",  32'(dina),  32'h10);
`endif
    checkOutput("col_done",  32'(done),   1);
    checkOutput("col_hmeas", 32'(h_meas), 1);
    checkOutput("col_vmeas", 32'(v_meas), 0);
    idle(4);
    checkOutput("col_writes", 32'(writeCount), 1);
    checkOutput("col_donecnt", 32'(doneCount), 1);

    $display("[TB] reset in the middle of a captured line");
    clearModel();
    pulseStart();
    vsyncPulse();
    idle(2);
    for (int l = 0; l < 3; l++) sendLine(l, 6, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    idle(1);
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 0, 0, pixR(3, c), pixG(3, c), pixB(3, c));
    checkOutput("pre_rst_wea", 32'(wea), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_wea",  32'(wea),  0);
    checkOutput("rst_mid_busy", 32'(busy), 0);
    checkOutput("rst_mid_done", 32'(done), 0);
    snapWrites = writeCount;
    idle(2);
    rst = 1'b0;
    for (int c = 3; c < 6; c++) applyStimulus(1, 0, 0, 0, pixR(3, c), pixG(3, c), pixB(3, c));
    idle(2);
    vsyncPulse();
    idle(4);
    checkOutput("rst_no_writes", 32'(writeCount), 32'(snapWrites));
    checkOutput("rst_no_done",   32'(doneCount),  0);
    clearModel();
    pulseStart();
    sendFrame(4, 2, 1);
    vsyncPulse();
    idle(4);
    checkOutput("rst_recap_writes", 32'(writeCount), 8);
    checkOutput("rst_recap_done",   32'(doneCount),  1);
    checkOutput("rst_recap_hmeas",  32'(h_meas),     4);
    checkOutput("rst_recap_vmeas",  32'(v_meas),     2);

    $display("[TB] start pulses while busy");
    clearModel();
    pulseStart();
    pulseStart();
    vsyncPulse();
    pulseStart();
    sendLine(0, 3, 1);
    sendLine(1, 3, 1);
    pulseStart();
    vsyncPulse();
    idle(4);
    checkOutput("busy_done",   32'(doneCount),  1);
    checkOutput("busy_writes", 32'(writeCount), 6);
    checkOutput("busy_hmeas",  32'(h_meas),     3);
    checkOutput("busy_vmeas",  32'(v_meas),     2);
    checkOutput("busy_idle",   32'(busy),       0);
    sendFrame(3, 2, 1);
    vsyncPulse();
    idle(4);
    checkOutput("busy_no_extra_done",  32'(doneCount),  1);
    checkOutput("busy_no_extra_write", 32'(writeCount), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
